pwm_bridge_gen: RTL

Multi-channel complementary PWM generator for the segway motor H-bridges. It is the generalised successor of the team's fixed 11-bit two-output PWM: width, channel count, dead time and blanking length are parameters. It adds shadowed duty registers loaded only at the period boundary, optional centre-aligned (up/down) counting, duty clamping, and a per-channel over-current blanking timer. It sits between the balance controller's duty outputs and the gate-drive pins, and its synch pulse goes to the A2D and current-sense logic.

---
 rtl/pwm_pkg.sv | 6 +
 rtl/pwm_chan.sv | 57 +++++
 rtl/pwm_bridge_gen.sv | 59 +++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode type and default timing constants for the PWM bridge.
package pwm_pkg;
  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
  localparam int DEAD_DFLT = 64;
  localparam int BLANK_DFLT = 128;
endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one complementary channel with duty shadow, clamp, dead-time compare and blanking timer.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEAD = DEAD_DFLT,
  parameter int BLANK_LEN = BLANK_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ld,
  input  pwm_mode_e        mode,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] duty,
  output logic             pwm_hi,
  output logic             pwm_lo,
  output logic             ovr_I_blank
);
  localparam int BW = $clog2(BLANK_LEN + 1);
  localparam logic [WIDTH:0] LO_C = (WIDTH+1)'(DEAD);
  localparam logic [WIDTH:0] HI_C = (WIDTH+1)'(2**WIDTH - 1 - DEAD);
  localparam logic [WIDTH-1:0] MAX_W = '1;
  logic [WIDTH-1:0] duty_q;
  logic [WIDTH:0] duty_x, duty_eff, cnt_x;
  logic hi_d, lo_d, hi_q, lo_q, ovr_q;
  logic [BW-1:0] bcnt_d, bcnt_q;
  always_comb begin
    duty_x = {1'b0, duty_q};
    cnt_x = {1'b0, cnt};
    duty_eff = duty_x < LO_C ? LO_C : duty_x > HI_C ? HI_C : duty_x;
    hi_d = en && cnt_x < duty_eff && (mode == PWM_CENTER || cnt_x >= LO_C);
    // edge mode keeps lo off at MAX so the wrap to hi still sees a dead gap
    lo_d = en && cnt_x >= duty_eff + LO_C && (mode == PWM_CENTER || cnt != MAX_W);
    bcnt_d = !en ? '0
           : ((hi_d && !hi_q) || (lo_d && !lo_q)) ? BW'(BLANK_LEN)
           : bcnt_q - BW'(bcnt_q != '0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      hi_q <= 1'b0;
      lo_q <= 1'b0;
      bcnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (ld) duty_q <= duty;
      hi_q <= hi_d;
      lo_q <= lo_d;
      bcnt_q <= bcnt_d;
      ovr_q <= bcnt_d != '0;
    end
  end
  assign pwm_hi = hi_q;
  assign pwm_lo = lo_q;
  assign ovr_I_blank = ovr_q;
endmodule

// File: rtl/pwm_bridge_gen.sv
// pwm_bridge_gen: multi-channel complementary PWM with shared edge/centre counter and period synch.
module pwm_bridge_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int NUM_CH = 2,
  parameter int DEAD = DEAD_DFLT,
  parameter int BLANK_LEN = BLANK_DFLT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    center_mode,
  input  logic [NUM_CH*WIDTH-1:0] duty,
  output logic [NUM_CH-1:0]       pwm_hi,
  output logic [NUM_CH-1:0]       pwm_lo,
  output logic                    pwm_synch,
  output logic [NUM_CH-1:0]       ovr_I_blank
);
  localparam logic [WIDTH-1:0] MAX_W = '1;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  logic dn_d, dn_q, synch_q, ld;
  pwm_mode_e mode_d, mode_q;
  always_comb begin
    ld = !en || (cnt_q == '0 && !dn_q);
    mode_d = ld ? pwm_mode_e'(center_mode) : mode_q;
    dn_d = en && mode_q == PWM_CENTER && (dn_q ? cnt_q != WIDTH'(1) : cnt_q == MAX_W);
    // the turn at the peak and the final step to 0 both count down
    cnt_d = !en ? '0 : (dn_q || dn_d) ? cnt_q - 1'b1 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dn_q <= 1'b0;
      mode_q <= PWM_EDGE;
      synch_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dn_q <= dn_d;
      mode_q <= mode_d;
      synch_q <= en && cnt_q == '0;
    end
  end
  assign pwm_synch = synch_q;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pwm_chan #(.WIDTH(WIDTH), .DEAD(DEAD), .BLANK_LEN(BLANK_LEN)) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .ld(ld),
      .mode(mode_q),
      .cnt(cnt_q),
      .duty(duty[k*WIDTH +: WIDTH]),
      .pwm_hi(pwm_hi[k]),
      .pwm_lo(pwm_lo[k]),
      .ovr_I_blank(ovr_I_blank[k])
    );
  end
endmodule
